// File: rtl/led_pattern_sequencer.sv
// Green-LED pattern sequencer: switch-selected prescaler tick, debounced mode
// button, and OFF/BLINK/CHASE/BOUNCE patterns that only change on tick edges.
module led_pattern_sequencer #(
  parameter int BASE_DIV  = 25000000,
  parameter int DB_CYCLES = 1000000
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       KEY_NEXT,
  input  logic [1:0] SPEED,
  input  logic       PAUSE,
  output logic [7:0] LEDG,
  output logic [1:0] MODE,
  output logic       TICK
);

  localparam int CNT_W = $clog2(BASE_DIV);
  localparam int DB_W  = $clog2(DB_CYCLES + 1);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_CHASE  = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             key_meta_q, key_meta_d;
  logic             key_sync_q, key_sync_d;
  logic             key_db_q, key_db_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic             pending_q, pending_d;
  logic             dir_q, dir_d;
  mode_e            mode_q, mode_d;
  logic [7:0]       ledg_q, ledg_d;

  logic [31:0]      term;
  logic             tick_fire;
  logic             press;

  // Greater-or-equal compare lets a SPEED change below the current count fire at once.
  assign term      = (32'(BASE_DIV) >> SPEED) - 32'd1;
  assign tick_fire = !PAUSE && (32'(cnt_q) >= term);

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = tick_fire;
    if (!PAUSE) begin
      if (tick_fire) cnt_d = '0;
      else           cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    key_meta_d = KEY_NEXT;
    key_sync_d = key_meta_q;
    key_db_d   = key_db_q;
    db_cnt_d   = '0;
    press      = 1'b0;
    if (key_sync_q != key_db_q) begin
      if (db_cnt_q == DB_W'(DB_CYCLES - 1)) begin
        key_db_d = key_sync_q;
        press    = !key_sync_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  always_comb begin
    mode_d    = mode_q;
    ledg_d    = ledg_q;
    dir_d     = dir_q;
    pending_d = pending_q;
    if (tick_fire) begin
      if (pending_q) begin
        pending_d = 1'b0;
        mode_d    = mode_e'(mode_q + 2'd1);
        dir_d     = DIR_LEFT;
        case (mode_d)
          MODE_OFF:   ledg_d = 8'h00;
          MODE_BLINK: ledg_d = 8'hFF;
          default:    ledg_d = 8'h01;
        endcase
      end else begin
        case (mode_q)
          MODE_OFF:   ledg_d = 8'h00;
          MODE_BLINK: ledg_d = ~ledg_q;
          MODE_CHASE: ledg_d = {ledg_q[6:0], ledg_q[7]};
          default: begin
            // Direction flips as an end is reached, so each end shows for one tick.
            if (dir_q == DIR_LEFT) begin
              ledg_d = {ledg_q[6:0], 1'b0};
              if (ledg_d == 8'h80) dir_d = DIR_RIGHT;
            end else begin
              ledg_d = {1'b0, ledg_q[7:1]};
              if (ledg_d == 8'h01) dir_d = DIR_LEFT;
            end
          end
        endcase
      end
    end
    // A press coinciding with a consuming tick re-arms for the following tick.
    if (press) pending_d = 1'b1;
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      cnt_q      <= '0;
      tick_q     <= 1'b0;
      key_meta_q <= 1'b1;
      key_sync_q <= 1'b1;
      key_db_q   <= 1'b1;
      db_cnt_q   <= '0;
      pending_q  <= 1'b0;
      dir_q      <= DIR_LEFT;
      mode_q     <= MODE_OFF;
      ledg_q     <= 8'h00;
    end else begin
      cnt_q      <= cnt_d;
      tick_q     <= tick_d;
      key_meta_q <= key_meta_d;
      key_sync_q <= key_sync_d;
      key_db_q   <= key_db_d;
      db_cnt_q   <= db_cnt_d;
      pending_q  <= pending_d;
      dir_q      <= dir_d;
      mode_q     <= mode_d;
      ledg_q     <= ledg_d;
    end
  end

  assign LEDG = ledg_q;
  assign MODE = mode_q;
  assign TICK = tick_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Scoreboard bench for led_pattern_sequencer: stimulus queues the expected
// {tick spacing, LEDG, MODE} of each tick; a monitor checks every TICK.
module tb_led_pattern_sequencer;

  logic       clk = 1'b0;
  logic       RESET;
  logic       KEY_NEXT;
  logic [1:0] SPEED;
  logic       PAUSE;
  logic [7:0] LEDG;
  logic [1:0] MODE;
  logic       TICK;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int last_tick   = 0;

  typedef struct {
    int         gap;
    logic [7:0] ledg;
    logic [1:0] mode;
  } exp_t;

  exp_t q[$];

  led_pattern_sequencer #(.BASE_DIV(8), .DB_CYCLES(4)) dut (
    .CLOCK_50(clk),
    .RESET   (RESET),
    .KEY_NEXT(KEY_NEXT),
    .SPEED   (SPEED),
    .PAUSE   (PAUSE),
    .LEDG    (LEDG),
    .MODE    (MODE),
    .TICK    (TICK)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every TICK must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    int   gap;
    if (RESET) begin
      last_tick = cyc + 1;
    end else if (TICK) begin
      vectors++;
      gap = cyc - last_tick;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_tick cycle=%0d: got LEDG=%h MODE=%0d gap=%0d, required no tick",
                 cyc, LEDG, MODE, gap);
      end else begin
        e = q.pop_front();
        if (gap != e.gap || LEDG !== e.ledg || MODE !== e.mode) begin
          miscompares++;
          $display("FAIL tick cycle=%0d: got gap=%0d LEDG=%h MODE=%0d, required gap=%0d LEDG=%h MODE=%0d",
                   cyc, gap, LEDG, MODE, e.gap, e.ledg, e.mode);
        end
      end
      last_tick = cyc;
    end
  end

  task automatic push(input int g, input logic [7:0] l, input logic [1:0] m);
    exp_t e;
    e.gap  = g;
    e.ledg = l;
    e.mode = m;
    q.push_back(e);
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_tick();
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!TICK && n < 64);
    if (!TICK) begin
      vectors++;
      miscompares++;
      $display("FAIL tick_timeout: got no TICK in %0d cycles, required one", n);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) wait_tick();
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Called right after a tick: pending is set before the next tick consumes it.
  task automatic press(input int g, input logic [7:0] l, input logic [1:0] m);
    KEY_NEXT = 1'b0;
    push(g, l, m);
    wait_tick();
    cyc_wait(2);
    KEY_NEXT = 1'b1;
  endtask

  logic [7:0] bounce_seq [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                  8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

  initial begin
    RESET    = 1'b1;
    KEY_NEXT = 1'b1;
    SPEED    = 2'd0;
    PAUSE    = 1'b0;
    cyc_wait(3);
    check("reset_ledg", LEDG, 8'h00);
    check("reset_mode", {6'd0, MODE}, 8'h00);
    check("reset_tick", {7'd0, TICK}, 8'h00);
    RESET = 1'b0;

    // Tick spacing at SPEED 0, 2 and 3.
    push(8, 8'h00, 2'd0); push(8, 8'h00, 2'd0); push(8, 8'h00, 2'd0);
    ticks(3);
    SPEED = 2'd2;
    push(2, 8'h00, 2'd0); push(2, 8'h00, 2'd0); push(2, 8'h00, 2'd0);
    ticks(3);
    SPEED = 2'd3;
    push(1, 8'h00, 2'd0); push(1, 8'h00, 2'd0); push(1, 8'h00, 2'd0);
    ticks(3);
    SPEED = 2'd0;
    push(8, 8'h00, 2'd0);
    wait_tick();

    // Count reaches 6, then term drops to 3: immediate tick, then every 4.
    cyc_wait(6);
    SPEED = 2'd1;
    push(7, 8'h00, 2'd0); push(4, 8'h00, 2'd0); push(4, 8'h00, 2'd0);
    ticks(3);
    SPEED = 2'd0;
    push(8, 8'h00, 2'd0);
    wait_tick();

    // Three-cycle glitch must not step the mode.
    KEY_NEXT = 1'b0;
    cyc_wait(3);
    KEY_NEXT = 1'b1;
    push(8, 8'h00, 2'd0); wait_tick();
    push(8, 8'h00, 2'd0); wait_tick();

    // BLINK.
    press(8, 8'hFF, 2'd1);
    push(8, 8'h00, 2'd1); push(8, 8'hFF, 2'd1);
    ticks(2);

    // CHASE.
    press(8, 8'h01, 2'd2);
    for (int i = 1; i < 8; i++) push(8, 8'(1 << i), 2'd2);
    push(8, 8'h01, 2'd2);
    ticks(8);

    // BOUNCE.
    press(8, 8'h01, 2'd3);
    for (int i = 0; i < 15; i++) push(8, bounce_seq[i], 2'd3);
    ticks(15);

    // Fourth press wraps to OFF.
    press(8, 8'h00, 2'd0);
    push(8, 8'h00, 2'd0);
    wait_tick();

    // PAUSE with a valid press: frozen for 30 cycles, step on first tick after.
    PAUSE    = 1'b1;
    KEY_NEXT = 1'b0;
    cyc_wait(10);
    KEY_NEXT = 1'b1;
    cyc_wait(20);
    check("pause_ledg", LEDG, 8'h00);
    check("pause_mode", {6'd0, MODE}, 8'h00);
    PAUSE = 1'b0;
    push(38, 8'hFF, 2'd1);
    wait_tick();

    // Into BOUNCE again, then reset mid-pattern.
    press(8, 8'h01, 2'd2);
    push(8, 8'h02, 2'd2);
    wait_tick();
    press(8, 8'h01, 2'd3);
    push(8, 8'h02, 2'd3); push(8, 8'h04, 2'd3);
    ticks(2);
    cyc_wait(3);
    RESET = 1'b1;
    cyc_wait(1);
    check("midreset_ledg", LEDG, 8'h00);
    check("midreset_mode", {6'd0, MODE}, 8'h00);
    check("midreset_tick", {7'd0, TICK}, 8'h00);
    RESET = 1'b0;
    push(8, 8'h00, 2'd0);
    wait_tick();
    cyc_wait(2);
    check("queue_drained", 8'(q.size()), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by 100000 ns, required earlier finish");
    $fatal(1);
  end

endmodule
